// File: rtl/dualport_ram_param_if.sv
// Port bundle for dualport_ram_param: write port, read port, read-valid strobe and ready.
// The RAM takes the slave modport; the client driving it takes the master modport.
`timescale 1ns/1ps
interface dualport_ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              we_en;
    logic [ADDR_W-1:0] we_addr;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [ADDR_W-1:0] re_addr;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              ready;

    modport master (
        output we_en, we_addr, din, rd_en, re_addr,
        input  dout, dout_valid, ready
    );

    modport slave (
        input  we_en, we_addr, din, rd_en, re_addr,
        output dout, dout_valid, ready
    );
endinterface

// File: rtl/dualport_ram_param.sv
// Simple dual-port RAM (1 write, 1 read, one clock) with post-reset clear sweep; OUTPUT_REG_EN adds an output stage.
// Latency: write 1 edge; read 1 edge (2 with OUTPUT_REG_EN); ready rises DEPTH edges after rst drops.
// Backpressure: none; we_en/rd_en are ignored while ready=0, otherwise one op per port per cycle.
`timescale 1ns/1ps
module dualport_ram_param #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 6,
    parameter int                DEPTH    = 1 << ADDR_W,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    parameter bit                RDW_MODE = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    dualport_ram_param_if.slave bus
);
    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              active;
    logic              wr_ok;
    logic              rd_in_range;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] dout_s1;
    logic              vld_s1;

    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_ptr == LAST_ADDR) begin
            state_d = READY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            clr_ptr <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                clr_ptr <= clr_ptr + ADDR_W'(1);
            end
        end
    end

    assign active      = (state_q == READY);
    assign wr_ok       = active && bus.we_en && ({1'b0, bus.we_addr} < DEPTH_X);
    assign rd_in_range = ({1'b0, bus.re_addr} < DEPTH_X);

    // Storage has no reset: the sweep, not rst, establishes the initial contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem[clr_ptr] <= INIT_VAL;
            end else if (wr_ok) begin
                mem[bus.we_addr] <= bus.din;
            end
        end
    end

    // Out-of-range reads return the clear value; same-address bypass only in write-first mode.
    always_comb begin
        rd_data = INIT_VAL;
        if (rd_in_range) begin
            if (RDW_MODE && wr_ok && bus.we_addr == bus.re_addr) begin
                rd_data = bus.din;
            end else begin
                rd_data = mem[bus.re_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_s1 <= '0;
            vld_s1  <= 1'b0;
        end else begin
            vld_s1 <= active && bus.rd_en;
            if (active && bus.rd_en) begin
                dout_s1 <= rd_data;
            end
        end
    end

`ifdef OUTPUT_REG_EN
    logic [DATA_W-1:0] dout_s2;
    logic              vld_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_s2 <= '0;
            vld_s2  <= 1'b0;
        end else begin
            vld_s2 <= vld_s1;
            if (vld_s1) begin
                dout_s2 <= dout_s1;
            end
        end
    end

    assign bus.dout       = dout_s2;
    assign bus.dout_valid = vld_s2;
`else
    assign bus.dout       = dout_s1;
    assign bus.dout_valid = vld_s1;
`endif

    assign bus.ready = active;
endmodule

// File: tb/tb_dualport_ram_param.sv
// Bench for dualport_ram_param: a 64-deep write-first instance and a 40-deep read-old instance
// share one stimulus stream and are checked every edge against an array-based reference model.
`timescale 1ns/1ps
module tb_dualport_ram_param;
`ifdef OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int MAXE = 4096;

    logic       clk = 1'b0;
    logic       rst;
    logic       we_en;
    logic [5:0] we_addr;
    logic [7:0] din;
    logic       rd_en;
    logic [5:0] re_addr;

    always #5 clk = ~clk;

    dualport_ram_param_if #(.DATA_W(8), .ADDR_W(6)) bus0 ();
    dualport_ram_param_if #(.DATA_W(8), .ADDR_W(6)) bus1 ();

    assign bus0.we_en = we_en;  assign bus0.we_addr = we_addr; assign bus0.din = din;
    assign bus0.rd_en = rd_en;  assign bus0.re_addr = re_addr;
    assign bus1.we_en = we_en;  assign bus1.we_addr = we_addr; assign bus1.din = din;
    assign bus1.rd_en = rd_en;  assign bus1.re_addr = re_addr;

    dualport_ram_param #(.DATA_W(8), .ADDR_W(6)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );
    dualport_ram_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(40), .RDW_MODE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    int         vectors = 0;
    int         miscompares = 0;
    int         edge_n = 0;
    int         since_rel = 0;
    int         rdy_at0 = -1;
    int         rdy_at1 = -1;
    int         cnt [2] = '{0, 0};
    int         last_rst [2] = '{-1, -1};
    logic [7:0] last_dout [2] = '{8'h00, 8'h00};
    logic [7:0] mmem [2][64];
    bit         issued [2][MAXE];
    logic [7:0] rdat [2][MAXE];
    logic [7:0] got0 [$];
    logic [7:0] got1 [$];

    function automatic int depth_of(input int k);
        return (k == 0) ? 64 : 40;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // Reference: words become INIT_VAL once DEPTH clean edges have passed; ports act only after that.
    task automatic model_edge(input int k);
        int dp;
        logic [7:0] r8;
        dp = depth_of(k);
        issued[k][edge_n] = 1'b0;
        if (rst) begin
            cnt[k] = 0;
            last_rst[k] = edge_n;
        end else if (cnt[k] >= dp) begin
            if (rd_en) begin
                if (int'(re_addr) >= dp)                        r8 = 8'h00;
                else if (k == 0 && we_en && we_addr == re_addr) r8 = din;
                else                                            r8 = mmem[k][re_addr];
                issued[k][edge_n] = 1'b1;
                rdat[k][edge_n]   = r8;
            end
            if (we_en && int'(we_addr) < dp) mmem[k][we_addr] = din;
        end else begin
            cnt[k]++;
            if (cnt[k] == dp) for (int a = 0; a < 64; a++) mmem[k][a] = 8'h00;
        end
    endtask

    task automatic check_dut(input int k, input logic rdy, input logic vld, input logic [7:0] dat);
        int src;
        logic ev;
        src = edge_n - (LAT - 1);
        if (last_rst[k] == edge_n) last_dout[k] = 8'h00;
        ev = (src >= 0 && src > last_rst[k]) ? issued[k][src] : 1'b0;
        if (ev) last_dout[k] = rdat[k][src];
        chk($sformatf("ready%0d@%0d", k, edge_n), 32'(rdy), 32'(cnt[k] >= depth_of(k)));
        chk($sformatf("valid%0d@%0d", k, edge_n), 32'(vld), 32'(ev));
        chk($sformatf("dout%0d@%0d", k, edge_n), 32'(dat), 32'(last_dout[k]));
    endtask

    task automatic cyc(input logic r, input logic w, input logic [5:0] wa, input logic [7:0] d,
                       input logic re, input logic [5:0] ra);
        rst = r; we_en = w; we_addr = wa; din = d; rd_en = re; re_addr = ra;
        @(posedge clk);
        #1;
        if (edge_n >= MAXE - 1) begin
            $display("FAIL edge_budget: observed %0d edges, limit %0d", edge_n, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        model_edge(0);
        model_edge(1);
        check_dut(0, bus0.ready, bus0.dout_valid, bus0.dout);
        check_dut(1, bus1.ready, bus1.dout_valid, bus1.dout);
        if (bus0.dout_valid === 1'b1) got0.push_back(bus0.dout);
        if (bus1.dout_valid === 1'b1) got1.push_back(bus1.dout);
        if (r) begin
            since_rel = 0; rdy_at0 = -1; rdy_at1 = -1;
        end else begin
            since_rel++;
            if (bus0.ready === 1'b1 && rdy_at0 < 0) rdy_at0 = since_rel;
            if (bus1.ready === 1'b1 && rdy_at1 < 0) rdy_at1 = since_rel;
        end
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, 6'd0);
    endtask

    task automatic rd(input logic [5:0] a);
        cyc(1'b0, 1'b0, 6'd0, 8'h00, 1'b1, a);
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while ((rdy_at0 < 0 || rdy_at1 < 0) && guard < 300) begin
            idle(1);
            guard++;
        end
        chk({tag, "_lat64"}, rdy_at0, 64);
        chk({tag, "_lat40"}, rdy_at1, 40);
    endtask

    task automatic clear_got();
        got0.delete();
        got1.delete();
    endtask

    task automatic chk_seq(input string tag, input int k, input int n,
                           input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        logic [7:0] e [3];
        int sz;
        e[0] = e0; e[1] = e1; e[2] = e2;
        sz = (k == 0) ? got0.size() : got1.size();
        chk($sformatf("%s_n%0d", tag, k), sz, n);
        for (int i = 0; i < n && i < sz; i++)
            chk($sformatf("%s_d%0d[%0d]", tag, k, i), (k == 0) ? got0[i] : got1[i], e[i]);
    endtask

    initial begin
        rst = 1'b1; we_en = 1'b0; we_addr = '0; din = '0; rd_en = 1'b0; re_addr = '0;

        // reset state, then sweep length
        cyc(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
        wait_ready("t1");

        // back-to-back reads
        clear_got();
        wr(6'd0, 8'hAA); wr(6'd1, 8'hBB); wr(6'd2, 8'hCC);
        rd(6'd0); rd(6'd1); rd(6'd2);
        idle(LAT + 1);
        chk_seq("t2", 0, 3, 8'hAA, 8'hBB, 8'hCC);
        chk_seq("t2", 1, 3, 8'hAA, 8'hBB, 8'hCC);

        // reset re-clears memory
        wr(6'd7, 8'h5A);
        idle(1);
        cyc(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
        wait_ready("t3");
        clear_got();
        rd(6'd7);
        idle(LAT + 1);
        chk_seq("t3", 0, 1, 8'h00, 8'h00, 8'h00);
        chk_seq("t3", 1, 1, 8'h00, 8'h00, 8'h00);

        // read-during-write, same address
        wr(6'd3, 8'h11);
        idle(1);
        clear_got();
        cyc(1'b0, 1'b1, 6'd3, 8'h3C, 1'b1, 6'd3);
        rd(6'd3);
        idle(LAT + 1);
        chk_seq("t4", 0, 2, 8'h3C, 8'h3C, 8'h00);
        chk_seq("t4", 1, 2, 8'h11, 8'h3C, 8'h00);

        // reset mid-sweep, port activity while not ready
        cyc(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
        idle(20);
        cyc(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
        cyc(1'b1, 1'b0, 6'd0, 8'h00, 1'b0, 6'd0);
        clear_got();
        idle(29);
        cyc(1'b0, 1'b1, 6'd2, 8'h99, 1'b1, 6'd5);
        wait_ready("t5");
        chk_seq("t5_blocked", 0, 0, 8'h00, 8'h00, 8'h00);
        chk_seq("t5_blocked", 1, 0, 8'h00, 8'h00, 8'h00);
        rd(6'd2);
        idle(LAT + 1);
        chk_seq("t5_nowrite", 0, 1, 8'h00, 8'h00, 8'h00);
        chk_seq("t5_nowrite", 1, 1, 8'h00, 8'h00, 8'h00);

        // address beyond DEPTH on the 40-deep instance
        clear_got();
        wr(6'd45, 8'h77);
        rd(6'd45);
        idle(LAT + 1);
        chk_seq("t6", 0, 1, 8'h77, 8'h00, 8'h00);
        chk_seq("t6", 1, 1, 8'h00, 8'h00, 8'h00);

        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 8'($urandom),
                1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)));
        end
        idle(LAT + 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
